serial_word_rx: RTL and testbench

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

---
 rtl/serial_rx_pkg.sv | 14 +
 rtl/swrx_bit_counter.sv | 28 ++
 rtl/serial_word_rx.sv | 153 +++++++++++++++
 tb/tb_serial_word_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and limits for the serial word receiver.
// The optional parity stage is enabled with SWRX_PARITY_EN.
package serial_rx_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PAR  = 2'd2
  } swrx_state_e;

endpackage

// File: rtl/swrx_bit_counter.sv
// Bit position counter: loads on start of word, counts strobes,
// flags the edge that carries the last data bit.
module swrx_bit_counter #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_rx.sv
// LSB-first serial word receiver with a one-deep output register.
// Define SWRX_PARITY_EN to add an even-parity bit after the data bits.
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun,
  output logic             par_err
);

  swrx_state_e state_q, state_d;

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word;
  logic shift_en;
  logic cnt_load;
  logic cnt_inc;
  logic last;
  logic complete;
  logic xfer;
  logic drop;

  swrx_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .clear(clear),
    .load (cnt_load),
    .inc  (cnt_inc),
    .last (last)
  );

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bit_en && sof) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (bit_en) begin
          shift_en = 1'b1;
          if (sof) begin
            cnt_load = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (last) begin
`ifdef SWRX_PARITY_EN
              state_d = ST_PAR;
`else
              complete = 1'b1;
              state_d  = ST_IDLE;
`endif
            end
          end
        end
      end
      ST_PAR: begin
        if (bit_en) begin
          if (sof) begin
            shift_en = 1'b1;
            cnt_load = 1'b1;
            state_d  = ST_RECV;
          end else begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Right shift: after WIDTH strobes bit 0 sits in position 0
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {sin, shift_q[WIDTH-1:1]};
    end
  end

`ifdef SWRX_PARITY_EN
  assign word = shift_q;
`else
  assign word = {sin, shift_q[WIDTH-1:1]};
`endif

  assign xfer = dout_valid && out_ready;
  assign drop = complete && dout_valid && !out_ready;
  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (complete && !drop) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (xfer) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SWRX_PARITY_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      par_err <= 1'b0;
    end else if (complete && !drop) begin
      par_err <= (^shift_q) ^ sin;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomised and directed bench for serial_word_rx against a word-level model.
module tb_serial_word_rx;

  localparam int WIDTH = 4;
`ifdef SWRX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic sin = 1'b0;
  logic bit_en = 1'b0;
  logic sof = 1'b0;
  logic out_ready = 1'b0;
  logic overrun_clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic busy;
  logic overrun;
  logic par_err;

  int n_tests = 0;
  int n_fail = 0;

  // reference model state
  bit m_recv;
  int m_cnt;
  int m_acc;
  bit m_valid;
  logic [WIDTH-1:0] m_dout;
  bit m_ovr;
  bit m_perr;

  serial_word_rx #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .sin        (sin),
    .bit_en     (bit_en),
    .sof        (sof),
    .out_ready  (out_ready),
    .overrun_clr(overrun_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset;
    m_recv = 0; m_cnt = 0; m_acc = 0;
    m_valid = 0; m_dout = '0; m_ovr = 0; m_perr = 0;
  endtask

  // One clock edge of the receiver, from the current input values
  task automatic model_edge;
    bit cmp;
    bit pe;
    bit drop;
    cmp = 0;
    pe = 0;
    if (bit_en) begin
      if (sof) begin
        m_recv = 1; m_cnt = 1; m_acc = int'(sin);
      end else if (m_recv) begin
        if (m_cnt < WIDTH) begin
          m_acc = m_acc + (int'(sin) << m_cnt);
          m_cnt++;
          if (m_cnt == WIDTH && !PAR_EN) begin
            cmp = 1; m_recv = 0;
          end
        end else begin
          cmp = 1; m_recv = 0;
          pe = (($countones(m_acc) % 2) == 1) ^ sin;
        end
      end
    end
    drop = cmp && m_valid && !out_ready;
    if (drop) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (cmp && !drop) begin
      m_dout = WIDTH'(m_acc); m_valid = 1; m_perr = pe;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic s, input logic f, input logic b,
                      input logic r, input logic oc);
    @(negedge clk);
    sin = s; sof = f; bit_en = b; out_ready = r; overrun_clr = oc;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2;
    bit_en = 0; sof = 0; out_ready = 0; overrun_clr = 0;
    clear = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset;
    @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input bit bad_par,
                           input logic rdy_pre, input logic rdy_last,
                           input logic oclr_last);
    int nb;
    logic b;
    nb = WIDTH + int'(PAR_EN);
    for (int i = 0; i < nb; i++) begin
      if (i < WIDTH) b = d[i];
      else b = (^d) ^ bad_par;
      if (i == nb - 1) step(b, i == 0, 1'b1, rdy_last, oclr_last);
      else step(b, i == 0, 1'b1, rdy_pre, 1'b0);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL rst_dout got=%h exp=0", dout); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", dout_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr got=%b exp=0", overrun); end
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr got=%b exp=0", par_err); end
    release_reset();
  endtask

  task automatic test_basic;
    do_reset();
    release_reset();
    send_word(4'b1101, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (dout !== 4'b1101) begin n_fail++; $display("FAIL basic_dout got=%h exp=d", dout); end
    n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", dout_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got=%b exp=0", busy); end
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr got=%b exp=0", par_err); end
    step(0, 0, 0, 1, 0);
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_onecyc got=%b exp=0", dout_valid); end
  endtask

  task automatic test_overrun;
    do_reset();
    release_reset();
    send_word(4'hA, 0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (dout !== 4'hA) begin n_fail++; $display("FAIL ovr_first got=%h exp=a", dout); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got=%b exp=0", overrun); end
    send_word(4'h5, 0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (dout !== 4'hA) begin n_fail++; $display("FAIL ovr_hold got=%h exp=a", dout); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    send_word(4'h9, 0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_setwins got=%b exp=1", overrun); end
    n_tests++; if (dout !== 4'hA) begin n_fail++; $display("FAIL ovr_hold2 got=%h exp=a", dout); end
    step(0, 0, 0, 1, 0);
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_xfer got=%b exp=0", dout_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    step(0, 0, 0, 1, 1);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_restart;
    do_reset();
    release_reset();
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy got=%b exp=1", busy); end
    send_word(4'h6, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (dout !== 4'h6) begin n_fail++; $display("FAIL rs_dout got=%h exp=6", dout); end
    n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL rs_valid got=%b exp=1", dout_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rs_ovr got=%b exp=0", overrun); end
    step(0, 0, 0, 1, 0);
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rs_once got=%b exp=0", dout_valid); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    release_reset();
    send_word(4'h9, 0, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
    do_reset();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rbusy got=%b exp=0", busy); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid got=%b exp=0", dout_valid); end
    n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL mid_rdout got=%h exp=0", dout); end
    release_reset();
    step(1, 0, 1, 1, 0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_nosof got=%b exp=0", busy); end
    send_word(4'hB, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (dout !== 4'hB) begin n_fail++; $display("FAIL mid_dout got=%h exp=b", dout); end
    n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got=%b exp=1", dout_valid); end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] w2;
    int nb;
    logic b;
    do_reset();
    release_reset();
    w2 = 4'hC;
    nb = WIDTH + int'(PAR_EN);
    send_word(4'h3, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (dout !== 4'h3) begin n_fail++; $display("FAIL b2b_w1 got=%h exp=3", dout); end
    // consumer stalls, then takes word 1 on the edge word 2 completes
    for (int i = 0; i < nb; i++) begin
      if (i < WIDTH) b = w2[i];
      else b = ^w2;
      step(b, i == 0, 1'b1, i == nb - 1, 1'b0);
      if (i == 0) begin
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_nogap got=%b exp=1", busy); end
      end
      n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_cont i=%0d got=%b exp=1", i, dout_valid); end
    end
    n_tests++; if (dout !== 4'hC) begin n_fail++; $display("FAIL b2b_w2 got=%h exp=c", dout); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr got=%b exp=0", overrun); end
    step(0, 0, 0, 1, 0);
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b exp=0", dout_valid); end
  endtask

`ifdef SWRX_PARITY_EN
  task automatic test_parity;
    do_reset();
    release_reset();
    send_word(4'h7, 0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (dout !== 4'h7) begin n_fail++; $display("FAIL par_dout got=%h exp=7", dout); end
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_good got=%b exp=0", par_err); end
    step(0, 0, 0, 1, 0);
    send_word(4'h7, 1, 1'b1, 1'b1, 1'b0);
    n_tests++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_bad got=%b exp=1", par_err); end
  endtask
`endif

  task automatic test_random;
    logic s, f, b, r, oc;
    do_reset();
    release_reset();
    for (int c = 0; c < 600; c++) begin
      b = ($urandom % 10) < 7;
      s = $urandom % 2;
      f = m_recv ? (($urandom % 12) == 0) : (($urandom % 3) == 0);
      r = ($urandom % 3) != 0;
      oc = ($urandom % 8) == 0;
      step(s, f, b, r, oc);
      n_tests++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, dout_valid, m_valid); end
      n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, dout, m_dout); end
      n_tests++; if (busy !== m_recv) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_recv); end
      n_tests++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_ovr c=%0d got=%b exp=%b", c, overrun, m_ovr); end
      n_tests++; if (par_err !== m_perr) begin n_fail++; $display("FAIL rnd_perr c=%0d got=%b exp=%b", c, par_err, m_perr); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overrun();
    test_restart();
    test_reset_mid();
    test_back_to_back();
`ifdef SWRX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
